// File: rtl/test_pattern_gen_pkg.sv
// Shared types and constants for the test pattern generator: mode encodings,
// pixel payload, bar geometry and the colour-bar table.
package test_pattern_gen_pkg;

  localparam int unsigned COORD_W   = 10;
  localparam int unsigned COLOR_W   = 4;
  localparam int unsigned MODE_W    = 3;
  localparam int unsigned BAR_WIDTH = 16;
  localparam int unsigned BAR_WRAP  = 624;
  localparam int unsigned BAR_PITCH = 80;
  localparam int unsigned NUM_BARS  = 8;

  typedef enum logic [MODE_W-1:0] {
    MODE_COLOR_BARS = 3'd0,
    MODE_CHECKER    = 3'd1,
    MODE_GRID       = 3'd2,
    MODE_MOVING_BAR = 3'd3,
    MODE_GRADIENT   = 3'd4
  } mode_e;

  typedef struct packed {
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
  } rgb_t;

  // {r,g,b} on/off per bar; index 0 (white) is the rightmost entry
  localparam logic [NUM_BARS-1:0][2:0] BAR_TABLE = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  function automatic rgb_t expand_rgb(logic [2:0] on);
    rgb_t c;
    c.red   = {COLOR_W{on[2]}};
    c.green = {COLOR_W{on[1]}};
    c.blue  = {COLOR_W{on[0]}};
    return c;
  endfunction

  function automatic mode_e next_mode(mode_e m);
    return (m == MODE_GRADIENT) ? MODE_COLOR_BARS : mode_e'(MODE_W'(m) + MODE_W'(1));
  endfunction

endpackage

// File: rtl/test_pattern_gen_if.sv
// Video timing in / pixel out bundle between the timing chain and the DAC.
interface test_pattern_gen_if;
  import test_pattern_gen_pkg::*;

  logic               hsync_in;
  logic               vsync_in;
  logic               isHorizontalActive;
  logic               isVerticalActive;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               mode_btn;
  logic [COLOR_W-1:0] red;
  logic [COLOR_W-1:0] green;
  logic [COLOR_W-1:0] blue;
  logic               hsync;
  logic               vsync;
  logic [MODE_W-1:0]  mode;

  modport master (
    output hsync_in, vsync_in, isHorizontalActive, isVerticalActive, x, y, mode_btn,
    input  red, green, blue, hsync, vsync, mode
  );

  modport slave (
    input  hsync_in, vsync_in, isHorizontalActive, isVerticalActive, x, y, mode_btn,
    output red, green, blue, hsync, vsync, mode
  );

endinterface

// File: rtl/test_pattern_gen_btn_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer; emits the
// accepted button level only.
module btn_debounce #(
  parameter int unsigned CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level
);

  localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] count;

  // Level is taken once the synchronised input has differed for CYCLES clocks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      level  <= 1'b0;
      count  <= '0;
    end else begin
      sync_q <= {sync_q[0], btn};
      if (sync_q[1] == level) begin
        count <= '0;
      end else if (count == CNT_W'(CYCLES - 1)) begin
        level <= sync_q[1];
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/test_pattern_gen.sv
// Test pattern generator: five selectable patterns behind a 2-stage pixel
// pipeline, mode stepped by a debounced button and applied only at frame start.
module test_pattern_gen
  import test_pattern_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned BAR_STEP        = 2
) (
  input  logic                clk,
  input  logic                rst,
  test_pattern_gen_if.slave   vid
);

  localparam int unsigned SUM_W = COORD_W + 1;

  logic               btn_level;
  logic               btn_level_q;
  logic               press_c;
  logic               vsync_prev;
  logic               frame_tick;
  logic               pending;
  mode_e              mode_q;
  logic [COORD_W-1:0] bar_pos;
  logic [SUM_W-1:0]   bar_sum_c;
  logic [COORD_W-1:0] bar_next_c;

  logic [COORD_W-1:0] x1;
  logic [COORD_W-1:0] y1;
  logic               hact1;
  logic               vact1;
  logic               hs1;
  logic               vs1;
  rgb_t               pixel_c;
  logic [COORD_W-1:0] bar_idx_c;
  rgb_t               pix2;
  logic               hs2;
  logic               vs2;
  logic               unused_y_msb;

  btn_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .btn   (vid.mode_btn),
    .level (btn_level)
  );

  assign press_c = btn_level & ~btn_level_q;

  always_comb begin
    bar_sum_c  = {1'b0, bar_pos} + SUM_W'(BAR_STEP);
    bar_next_c = (bar_sum_c > SUM_W'(BAR_WRAP)) ? '0 : bar_sum_c[COORD_W-1:0];
  end

  // Frame tick, press-pending flag, mode and bar position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_level_q <= 1'b0;
      vsync_prev  <= 1'b1;
      frame_tick  <= 1'b0;
      pending     <= 1'b0;
      mode_q      <= MODE_COLOR_BARS;
      bar_pos     <= '0;
    end else begin
      btn_level_q <= btn_level;
      vsync_prev  <= vid.vsync_in;
      frame_tick  <= vsync_prev & ~vid.vsync_in;
      if (frame_tick) begin
        pending <= 1'b0;
        bar_pos <= bar_next_c;
        if (pending | press_c) mode_q <= next_mode(mode_q);
      end else if (press_c) begin
        pending <= 1'b1;
      end
    end
  end

  always_comb begin
    pixel_c   = '0;
    bar_idx_c = x1 / COORD_W'(BAR_PITCH);
    case (mode_q)
      MODE_COLOR_BARS:
        if (bar_idx_c < COORD_W'(NUM_BARS)) pixel_c = expand_rgb(BAR_TABLE[bar_idx_c[2:0]]);
      MODE_CHECKER:
        if (x1[5] ^ y1[5]) pixel_c = expand_rgb(3'b111);
      MODE_GRID:
        pixel_c = (x1[4:0] == '0 || y1[4:0] == '0) ? expand_rgb(3'b111)
                                                   : '{red: 4'h0, green: 4'h0, blue: 4'h4};
      MODE_MOVING_BAR:
        if (x1 >= bar_pos && x1 < bar_pos + COORD_W'(BAR_WIDTH)) pixel_c = expand_rgb(3'b111);
      MODE_GRADIENT:
        pixel_c = '{red: x1[9:6], green: y1[8:5], blue: 4'h0};
      default: ;
    endcase
    if (!(hact1 && vact1)) pixel_c = '0;
  end

  assign unused_y_msb = y1[COORD_W-1];

  // Stage 1 captures timing, stage 2 holds the finished pixel and syncs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x1    <= '0;
      y1    <= '0;
      hact1 <= 1'b0;
      vact1 <= 1'b0;
      hs1   <= 1'b1;
      vs1   <= 1'b1;
      pix2  <= '0;
      hs2   <= 1'b1;
      vs2   <= 1'b1;
    end else begin
      x1    <= vid.x;
      y1    <= vid.y;
      hact1 <= vid.isHorizontalActive;
      vact1 <= vid.isVerticalActive;
      hs1   <= vid.hsync_in;
      vs1   <= vid.vsync_in;
      pix2  <= pixel_c;
      hs2   <= hs1;
      vs2   <= vs1;
    end
  end

  assign vid.red   = pix2.red;
  assign vid.green = pix2.green;
  assign vid.blue  = pix2.blue;
  assign vid.hsync = hs2;
  assign vid.vsync = vs2;
  assign vid.mode  = MODE_W'(mode_q);

endmodule

// File: tb/tb_test_pattern_gen.sv
// Randomised bench for test_pattern_gen against a frame-level reference model.
module tb_test_pattern_gen;

  localparam int BAR_STEP = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  int   model_mode = 0;
  int   model_bar  = 0;
  bit   model_pend = 0;

  logic [13:0] exp_q [$];
  string       tag_q [$];
  logic [11:0] bar_rgb [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                               12'hF0F, 12'hF00, 12'h00F, 12'h000};

  test_pattern_gen_if vid ();

  test_pattern_gen #(
    .DEBOUNCE_CYCLES (4),
    .BAR_STEP        (BAR_STEP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .vid (vid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ref_rgb(int m, int bp, int xx, int yy);
    case (m)
      0: return (xx / 80 > 7) ? 12'h000 : bar_rgb[xx / 80];
      1: return (((xx / 32) + (yy / 32)) % 2 == 1) ? 12'hFFF : 12'h000;
      2: return (xx % 32 == 0 || yy % 32 == 0) ? 12'hFFF : 12'h004;
      3: return (xx >= bp && xx < bp + 16) ? 12'hFFF : 12'h000;
      default: return {4'(xx / 64), 4'((yy / 32) % 16), 4'h0};
    endcase
  endfunction

  function automatic logic [13:0] observed();
    return {vid.red, vid.green, vid.blue, vid.hsync, vid.vsync};
  endfunction

  task automatic pix_cycle(input int xx, input int yy, input bit ha, input bit va,
                           input bit hs, input string tag);
    logic [11:0] rgb;
    @(negedge clk);
    if (exp_q.size() == 2) chk(tag_q.pop_front(), 32'(observed()), 32'(exp_q.pop_front()));
    vid.x = 10'(xx);
    vid.y = 10'(yy);
    vid.isHorizontalActive = ha;
    vid.isVerticalActive   = va;
    vid.hsync_in = hs;
    rgb = (ha && va) ? ref_rgb(model_mode, model_bar, xx, yy) : 12'h000;
    exp_q.push_back({rgb, hs, 1'b1});
    tag_q.push_back(tag);
  endtask

  task automatic pix_drain();
    while (exp_q.size() > 0) begin
      @(negedge clk);
      chk(tag_q.pop_front(), 32'(observed()), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic run_random(input int n, input string tag);
    for (int i = 0; i < n; i++)
      pix_cycle($urandom_range(0, 1023), $urandom_range(0, 1023),
                $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 7) != 0, tag);
    pix_drain();
  endtask

  task automatic press();
    @(negedge clk) vid.mode_btn = 1'b1;
    @(negedge clk) vid.mode_btn = 1'b0;
    @(negedge clk) vid.mode_btn = 1'b1;
    repeat (10) @(negedge clk);
    vid.mode_btn = 1'b0;
    repeat (10) @(negedge clk);
    model_pend = 1;
  endtask

  task automatic do_frame();
    @(negedge clk) vid.vsync_in = 1'b0;
    @(negedge clk) chk("vsync_1cyc", 32'(vid.vsync), 32'd1);
    @(negedge clk) chk("vsync_2cyc", 32'(vid.vsync), 32'd0);
    repeat (3) @(negedge clk);
    vid.vsync_in = 1'b1;
    repeat (4) @(negedge clk);
    model_bar = (model_bar + BAR_STEP > 624) ? 0 : model_bar + BAR_STEP;
    if (model_pend) begin
      model_mode = (model_mode + 1) % 5;
      model_pend = 0;
    end
    chk("mode_tick", 32'(vid.mode), 32'(model_mode));
  endtask

  initial begin
    rst = 1'b1;
    vid.hsync_in = 1'b1;
    vid.vsync_in = 1'b1;
    vid.isHorizontalActive = 1'b0;
    vid.isVerticalActive   = 1'b0;
    vid.x = '0;
    vid.y = '0;
    vid.mode_btn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pixel", 32'(observed()), 32'({12'h000, 1'b1, 1'b1}));
    chk("rst_mode", 32'(vid.mode), 32'd0);
    rst = 1'b0;

    for (int xx = 0; xx < 640; xx++)
      pix_cycle(xx, 100, 1'b1, 1'b1, 1'b1,
                xx == 85 ? "bars_x85" : (xx == 600 ? "bars_x600" : "bars_sweep"));
    pix_cycle(10, 100, 1'b0, 1'b1, 1'b1, "bars_hinactive");
    pix_cycle(10, 100, 1'b0, 1'b1, 1'b0, "hsync_pulse");
    pix_cycle(700, 100, 1'b1, 1'b1, 1'b1, "bars_beyond");
    pix_drain();
    run_random(200, "rand_mode0");

    press();
    chk("mode_hold_midframe", 32'(vid.mode), 32'd0);
    do_frame();
    run_random(150, "rand_mode1");

    press();
    press();
    chk("mode_hold_2press", 32'(vid.mode), 32'd1);
    do_frame();
    run_random(150, "rand_mode2");

    pix_cycle(0, 0, 1'b1, 1'b1, 1'b0, "pre_rst");
    pix_cycle(0, 0, 1'b1, 1'b1, 1'b0, "pre_rst");
    pix_drain();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pixel", 32'(observed()), 32'({12'h000, 1'b1, 1'b1}));
    chk("async_rst_mode", 32'(vid.mode), 32'd0);
    vid.hsync_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_mode = 0;
    model_bar  = 0;
    model_pend = 0;
    press();
    repeat (20) @(negedge clk);
    chk("no_tick_after_rst", 32'(vid.mode), 32'd0);
    do_frame();
    press();
    do_frame();
    press();
    do_frame();
    for (int i = 0; i < 120; i++)
      pix_cycle((model_bar + $urandom_range(0, 60) + 1004) % 1024, $urandom_range(0, 1023),
                1'b1, 1'b1, 1'b1, "rand_bar");
    pix_drain();

    while (model_bar != 624) do_frame();
    pix_cycle(623, 50, 1'b1, 1'b1, 1'b1, "bar624_x623");
    pix_cycle(624, 50, 1'b1, 1'b1, 1'b1, "bar624_x624");
    pix_cycle(639, 50, 1'b1, 1'b1, 1'b1, "bar624_x639");
    pix_cycle(640, 50, 1'b1, 1'b1, 1'b1, "bar624_x640");
    pix_drain();
    do_frame();
    pix_cycle(0, 50, 1'b1, 1'b1, 1'b1, "bar0_x0");
    pix_cycle(15, 50, 1'b1, 1'b1, 1'b1, "bar0_x15");
    pix_cycle(16, 50, 1'b1, 1'b1, 1'b1, "bar0_x16");
    pix_drain();

    press();
    do_frame();
    run_random(150, "rand_mode4");
    press();
    do_frame();
    run_random(50, "rand_mode0_wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/test_pattern_gen.md
TEST_PATTERN_GEN -- requirements
Module: test_pattern_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, stable-input cycles before mode_btn level is accepted (10 ms at 25 MHz).
REQ-002 Parameter BAR_STEP, default 2, pixels the moving bar advances per frame.
REQ-003 clk  input  1  pixel clock; every register in the block is clocked on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 hsync_in  input  1  active-low horizontal sync from the horizontal timing stage.
REQ-006 vsync_in  input  1  active-low vertical sync from the vertical timing stage.
REQ-007 isHorizontalActive  input  1  high while x is inside the visible line.
REQ-008 isVerticalActive  input  1  high while y is inside the visible frame.
REQ-009 x  input  10  current pixel column.
REQ-010 y  input  10  current line.
REQ-011 mode_btn  input  1  raw, asynchronous, bouncing push-button, active-high.
REQ-012 red, green, blue  output  4 each  pixel colour to the DAC.
REQ-013 hsync, vsync  output  1 each  sync outputs, aligned to the colour outputs.
REQ-014 mode  output  3  currently displayed pattern.

Function
REQ-015 Latency from x/y/active/sync inputs to the colour/sync outputs SHALL be exactly 2 clk cycles.
REQ-016 hsync and vsync SHALL be the input syncs delayed 2 cycles and otherwise unmodified.
REQ-017 Colour SHALL be 0/0/0 whenever the 2-cycle-delayed isHorizontalActive AND isVerticalActive is 0.
REQ-018 Mode 0 COLOR_BARS: bar index = x/80, in the order white, yellow, cyan, green, magenta, red, blue, black.
REQ-019 In mode 0, each channel SHALL be 4'hF or 4'h0; index >7 (x>=640) SHALL give black.
REQ-020 Mode 1 CHECKER: white (F/F/F) if x[5] XOR y[5] is 1, else black.
REQ-021 Mode 2 GRID: white if x[4:0]==0 or y[4:0]==0, else red=0, green=0, blue=4'h4.
REQ-022 Mode 3 MOVING_BAR: white if bar_pos <= x < bar_pos+16, else black.
REQ-023 Mode 4 GRADIENT: red=x[9:6], green=y[8:5], blue=0.
REQ-024 Frame tick SHALL be a 1-cycle pulse on the cycle after vsync_in is sampled going 1->0.
REQ-025 On a frame tick, bar_pos SHALL become 0 if bar_pos+BAR_STEP > 624, else bar_pos+BAR_STEP.
REQ-026 bar_pos SHALL advance on every frame tick regardless of the current mode.
REQ-027 bar_pos and all comparisons SHALL be 10-bit unsigned.
REQ-028 A rising edge of the debounced button level SHALL set a pending flag.
REQ-029 The pending flag SHALL saturate: several presses within one frame give one advance.
REQ-030 On a frame tick with pending set, mode SHALL advance 0->1->2->3->4->0 and pending SHALL clear.
REQ-031 A press edge in the same cycle as a frame tick SHALL be applied at that tick.
REQ-032 mode SHALL change only on frame ticks, so no pattern tearing occurs mid-frame.

Reset
REQ-033 While rst is high: red/green/blue=0, hsync=1, vsync=1, mode=0, bar_pos=0, pending=0.
REQ-034 While rst is high: all pipeline registers cleared, active bits cleared, sync bits set to 1.
REQ-035 While rst is high: debounced level=0, debounce counter=0, previous-vsync register=1.
REQ-036 Reset asserted mid-frame SHALL take effect immediately; the first tick after release needs a fresh vsync_in 1->0 edge.

Structure
REQ-037 A shared package SHALL hold the mode encodings, the bar width (16), the bar-wrap limit (624) and the colour-bar table.
REQ-038 Sub-module btn_debounce SHALL implement a 2-FF synchroniser plus stable-count debouncer (level output only).
REQ-039 Edge detection, pending flag, bar_pos and the 2-stage pixel pipeline SHALL reside in test_pattern_gen.

Verification
REQ-040 Mode 0, y=100, both actives high, x swept 0..639: x=85 yields F/F/0 and x=600 yields 0/0/0, each 2 cycles after input.
REQ-041 Mode 0 with isHorizontalActive=0 at x=10: colour=0/0/0 2 cycles later; hsync_in pulse reproduced exactly 2 cycles later.
REQ-042 DEBOUNCE_CYCLES=4, mode_btn bounces 1-0-1 then held 10 cycles mid-frame: mode stays 0 until the next vsync_in fall, then mode=1.
REQ-043 Two clean presses in one frame: mode advances by exactly 1 at the next tick.
REQ-044 Mode 3, bar_pos=624, vsync_in falls: bar_pos=0; then x=15 yields white and x=16 yields black.
REQ-045 rst asserted mid-frame while mode=2: outputs reach reset values asynchronously; after release, the bar does not move before a new vsync_in fall.
